multicycle_ctrl_fsm: RTL and testbench

//  Next-generation multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback.

---
 rtl/multicycle_ctrl_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control unit: Moore FSM for fetch/decode/execute/memory/writeback with memory wait states.
// Build option ILLEGAL_TRAP_EN: illegal opcodes halt in TRAP instead of retiring as a NOP.
module multicycle_ctrl_fsm #(
  parameter int                  OPCODE_W = 6,
  parameter int                  MEM_LAT  = 0,
  parameter logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000,
  parameter logic [OPCODE_W-1:0] OP_LW    = 6'b100011,
  parameter logic [OPCODE_W-1:0] OP_SW    = 6'b101011,
  parameter logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100,
  parameter logic [OPCODE_W-1:0] OP_BNE   = 6'b000101,
  parameter logic [OPCODE_W-1:0] OP_J     = 6'b000010,
  parameter logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [1:0]          ALUOp,
  output logic                ALUInSel1,
  output logic [1:0]          ALUInSel2,
  output logic                MtoRFSel,
  output logic                RFDSel,
  output logic                IDSel,
  output logic [1:0]          PCSel,
  output logic                IRWE,
  output logic                PCWE,
  output logic                DMWE,
  output logic                RFWE,
  output logic                Branch,
  output logic                BranchNE,
  output logic                illegal,
  output logic [3:0]          state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_BNE     = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state_r;
  state_t     state_n;
  logic [3:0] cnt_r;
  logic [3:0] cnt_n;
  logic       illegal_r;
  logic       illegal_n;
  logic       run_r;
  logic       last_s;
  logic [3:0] out_sel_s;

  logic op_lw_s, op_sw_s, op_rtype_s, op_beq_s, op_bne_s, op_j_s, op_addi_s;

  assign op_lw_s    = (opcode == OP_LW);
  assign op_sw_s    = (opcode == OP_SW);
  assign op_rtype_s = (opcode == OP_RTYPE);
  assign op_beq_s   = (opcode == OP_BEQ);
  assign op_bne_s   = (opcode == OP_BNE);
  assign op_j_s     = (opcode == OP_J);
  assign op_addi_s  = (opcode == OP_ADDI);

  // Final cycle of a memory access: the wait counter has run through MEM_LAT extra cycles.
  assign last_s = (cnt_r == LAT);

  // run_r is low from reset until the first clock edge after release, so the
  // release cycle carries no strobes and FETCH does not count it as a wait cycle.
  // State, wait counter, sticky illegal flag and run qualifier.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= S_FETCH;
      cnt_r     <= 4'd0;
      illegal_r <= 1'b0;
      run_r     <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      illegal_r <= illegal_n;
      run_r     <= 1'b1;
    end
  end

  // Next-state, wait-counter and illegal-flag logic.
  always_comb begin
    state_n   = state_r;
    illegal_n = illegal_r;
    cnt_n     = cnt_r;
    if (run_r) begin
      case (state_r)
        S_FETCH:   state_n = last_s ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (op_lw_s || op_sw_s) begin
            state_n = S_MEMADR;
          end else if (op_rtype_s) begin
            state_n = S_EXEC;
          end else if (op_beq_s) begin
            state_n = S_BEQ;
          end else if (op_bne_s) begin
            state_n = S_BNE;
          end else if (op_j_s) begin
            state_n = S_JUMP;
          end else if (op_addi_s) begin
            state_n = S_ADDI_EX;
          end else begin
            illegal_n = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            state_n   = S_TRAP;
`else
            state_n   = S_FETCH;
`endif
          end
        end
        S_MEMADR: begin
          if (op_lw_s) begin
            state_n = S_MEMRD;
          end else if (op_sw_s) begin
            state_n = S_MEMWR;
          end else begin
            state_n = S_FETCH;
          end
        end
        S_MEMRD:   state_n = last_s ? S_MEMWB : S_MEMRD;
        S_MEMWB:   state_n = S_FETCH;
        S_MEMWR:   state_n = last_s ? S_FETCH : S_MEMWR;
        S_EXEC:    state_n = S_ALUWB;
        S_ALUWB:   state_n = S_FETCH;
        S_BEQ:     state_n = S_FETCH;
        S_BNE:     state_n = S_FETCH;
        S_JUMP:    state_n = S_FETCH;
        S_ADDI_EX: state_n = S_ADDI_WB;
        S_ADDI_WB: state_n = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:    state_n = S_TRAP;
`else
        S_TRAP:    state_n = S_FETCH;
`endif
        default:   state_n = S_FETCH;
      endcase
      if (state_n != state_r) begin
        cnt_n = 4'd0;
      end else if (cnt_r != LAT) begin
        cnt_n = cnt_r + 4'd1;
      end else begin
        cnt_n = cnt_r;
      end
    end else begin
      state_n = S_FETCH;
    end
  end

  // Until run_r rises the decode is steered to an unused code, which drives everything to 0.
  assign out_sel_s = run_r ? state_r : 4'd15;

  // Moore output decode.
  always_comb begin
    ALUOp     = 2'b00;
    ALUInSel1 = 1'b0;
    ALUInSel2 = 2'b00;
    MtoRFSel  = 1'b0;
    RFDSel    = 1'b0;
    IDSel     = 1'b0;
    PCSel     = 2'b00;
    IRWE      = 1'b0;
    PCWE      = 1'b0;
    DMWE      = 1'b0;
    RFWE      = 1'b0;
    Branch    = 1'b0;
    BranchNE  = 1'b0;
    case (out_sel_s)
      S_FETCH: begin
        ALUInSel2 = 2'b01;
        IRWE      = last_s;
        PCWE      = last_s;
      end
      S_DECODE: ALUInSel2 = 2'b10;
      S_MEMADR, S_ADDI_EX: begin
        ALUInSel1 = 1'b1;
        ALUInSel2 = 2'b10;
      end
      S_MEMRD: IDSel = 1'b1;
      S_MEMWB: begin
        MtoRFSel = 1'b1;
        RFWE     = 1'b1;
      end
      S_MEMWR: begin
        IDSel = 1'b1;
        DMWE  = last_s;
      end
      S_EXEC: begin
        ALUInSel1 = 1'b1;
        ALUOp     = 2'b10;
      end
      S_ALUWB: begin
        RFDSel = 1'b1;
        RFWE   = 1'b1;
      end
      S_BEQ: begin
        ALUInSel1 = 1'b1;
        ALUOp     = 2'b01;
        PCSel     = 2'b01;
        Branch    = 1'b1;
      end
      S_BNE: begin
        ALUInSel1 = 1'b1;
        ALUOp     = 2'b01;
        PCSel     = 2'b01;
        BranchNE  = 1'b1;
      end
      S_JUMP: begin
        PCSel = 2'b10;
        PCWE  = 1'b1;
      end
      S_ADDI_WB: RFWE = 1'b1;
      default: ALUOp = 2'b00;
    endcase
  end

  assign illegal = illegal_r;
  assign state_o = state_r;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomised bench for multicycle_ctrl_fsm: three instances (MEM_LAT 0, 2, 3) checked every cycle
// against per-instruction cycle tables built from opcode and latency, plus hand-computed trace pins.
module tb_multicycle_ctrl_fsm;
  localparam int NI = 3;

  logic        CLK;
  logic        RST;
  logic [5:0]  opcode [NI];
  logic [20:0] obs [NI];

  // Observed vector: {state[20:17], illegal, ALUOp, Sel1, Sel2, MtoRF, RFD, ID, PCSel, IRWE, PCWE, DMWE, RFWE, Branch, BranchNE}
  logic [20:0] seq [NI][32];
  int          len [NI];
  int          pos [NI];
  logic        ill [NI];
  logic [20:0] tr [32];
  int          vectors;
  int          errors;
  int          exp_st [10];
  int          cnt;
  bit          found;

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    logic [1:0] alu_op, sel2, pc_sel;
    logic       sel1, m2r, rfd, ids, irwe, pcwe, dmwe, rfwe, br, bne, ill_o;
    logic [3:0] st;
    multicycle_ctrl_fsm #(.MEM_LAT(L)) dut (
      .CLK(CLK), .RST(RST), .opcode(opcode[g]),
      .ALUOp(alu_op), .ALUInSel1(sel1), .ALUInSel2(sel2), .MtoRFSel(m2r), .RFDSel(rfd),
      .IDSel(ids), .PCSel(pc_sel), .IRWE(irwe), .PCWE(pcwe), .DMWE(dmwe), .RFWE(rfwe),
      .Branch(br), .BranchNE(bne), .illegal(ill_o), .state_o(st)
    );
    assign obs[g] = {st, ill_o, alu_op, sel1, sel2, m2r, rfd, ids, pc_sel, irwe, pcwe, dmwe, rfwe, br, bne};
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [20:0] mk(input logic [3:0] st, input logic [1:0] alu, input logic s1,
                                     input logic [1:0] s2, input logic m, input logic rd, input logic id,
                                     input logic [1:0] pc, input logic [5:0] stb);
    return {st, 1'b0, alu, s1, s2, m, rd, id, pc, stb};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b001000};
  endfunction

  task automatic push(input int k, input logic [20:0] r);
    seq[k][len[k]] = {r[20:17], ill[k], r[15:0]};
    len[k]++;
  endtask

  // Expected cycle table of one instruction: FETCH takes L+1 cycles, DECODE one, then the opcode's path.
  task automatic build(input int k, input logic [5:0] op);
    int lat = lat_of(k);
    len[k] = 0;
    pos[k] = 0;
    for (int c = 0; c <= lat; c++)
      push(k, mk(4'd0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, (c == lat) ? 6'b110000 : 6'b000000));
    push(k, mk(4'd1, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 6'b000000));
    case (op)
      6'b100011: begin
        push(k, mk(4'd2, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 6'b000000));
        for (int c = 0; c <= lat; c++)
          push(k, mk(4'd3, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 6'b000000));
        push(k, mk(4'd4, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 6'b000100));
      end
      6'b101011: begin
        push(k, mk(4'd2, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 6'b000000));
        for (int c = 0; c <= lat; c++)
          push(k, mk(4'd5, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, (c == lat) ? 6'b001000 : 6'b000000));
      end
      6'b000000: begin
        push(k, mk(4'd6, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 6'b000000));
        push(k, mk(4'd7, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 6'b000100));
      end
      6'b000100: push(k, mk(4'd8, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 6'b000010));
      6'b000101: push(k, mk(4'd12, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 6'b000001));
      6'b000010: push(k, mk(4'd9, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 6'b010000));
      6'b001000: begin
        push(k, mk(4'd10, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 6'b000000));
        push(k, mk(4'd11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 6'b000100));
      end
      default: ill[k] = 1'b1;
    endcase
  endtask

  function automatic logic [5:0] pick();
    logic [5:0] op;
    case ($urandom_range(0, 7))
      0: op = 6'b100011;
      1: op = 6'b101011;
      2: op = 6'b000000;
      3: op = 6'b000100;
      4: op = 6'b000101;
      5: op = 6'b000010;
      6: op = 6'b001000;
      default: op = 6'($urandom_range(0, 63));
    endcase
`ifdef ILLEGAL_TRAP_EN
    if (!is_legal(op)) op = 6'b000000;
`endif
    return op;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      len[k] = 0;
      pos[k] = 0;
      ill[k] = 1'b0;
    end
  endtask

  // One clock of the per-cycle comparison against the model tables.
  task automatic step();
    logic [5:0] op;
    @(negedge CLK);
    for (int k = 0; k < NI; k++) begin
      if (pos[k] == len[k]) begin
        op = pick();
        opcode[k] = op;
        build(k, op);
      end
      vectors++;
      if (obs[k] !== seq[k][pos[k]]) begin
        errors++;
        $display("FAIL model inst%0d (MEM_LAT=%0d) op=%b idx=%0d: got %h expected %h",
                 k, lat_of(k), opcode[k], pos[k], obs[k], seq[k][pos[k]]);
      end
      pos[k]++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reset, apply op to every instance, release, then capture n cycles of instance k.
  task automatic pin(input int k, input logic [5:0] op, input int n);
    @(negedge CLK);
    RST = 1'b1;
    for (int j = 0; j < NI; j++) opcode[j] = op;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      tr[i] = obs[k];
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    RST     = 1'b1;
    for (int k = 0; k < NI; k++) opcode[k] = 6'b000000;
    model_reset();

    @(negedge CLK);
    for (int k = 0; k < NI; k++) chk($sformatf("reset_zero_inst%0d", k), 32'(obs[k]), 32'd0);
    RST = 1'b0;
    repeat (400) step();

    // Asynchronous reset while the MEM_LAT=3 instance sits in MEMRD.
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      step();
      if (obs[2][20:17] == 4'd3) found = 1'b1;
    end
    if (!found) begin
      vectors++;
      errors++;
      $display("FAIL memrd_wait: got no MEMRD expected MEMRD within 500 cycles");
    end
    #2 RST = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) chk($sformatf("async_reset_zero_inst%0d", k), 32'(obs[k]), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    repeat (300) step();

    // lw, MEM_LAT=0
    exp_st = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0};
    pin(0, 6'b100011, 6);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("lw_state%0d", i), 32'(tr[i][20:17]), 32'(exp_st[i]));
      cnt += int'(tr[i][2]);
    end
    chk("lw_irwe_pcwe_c1", 32'(tr[0][5:4]), 32'h3);
    chk("lw_rfwe_mtorf_c5", 32'({tr[4][2], tr[4][10]}), 32'h3);
    chk("lw_rfwe_count", 32'(cnt), 32'd1);

    // sw, MEM_LAT=2: 3 FETCH, DECODE, MEMADR, 3 MEMWR
    exp_st = '{0, 0, 0, 1, 2, 5, 5, 5, 0, 0};
    pin(1, 6'b101011, 9);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("sw_state%0d", i), 32'(tr[i][20:17]), 32'(exp_st[i]));
      cnt += int'(tr[i][3]);
    end
    chk("sw_dmwe_count", 32'(cnt), 32'd1);
    chk("sw_dmwe_last", 32'(tr[7][3]), 32'd1);
    chk("sw_irwe_third", 32'({tr[0][5], tr[1][5], tr[2][5]}), 32'b001);

    // bne, MEM_LAT=0
    exp_st = '{0, 1, 12, 0, 0, 0, 0, 0, 0, 0};
    pin(0, 6'b000101, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("bne_state%0d", i), 32'(tr[i][20:17]), 32'(exp_st[i]));
    chk("bne_branch_bits", 32'(tr[2][1:0]), 32'b01);
    chk("bne_aluop", 32'(tr[2][15:14]), 32'b01);
    chk("bne_pcsel", 32'(tr[2][7:6]), 32'b01);

    // addi, MEM_LAT=0
    exp_st = '{0, 1, 10, 11, 0, 0, 0, 0, 0, 0};
    pin(0, 6'b001000, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("addi_state%0d", i), 32'(tr[i][20:17]), 32'(exp_st[i]));
    chk("addi_sel2", 32'(tr[2][12:11]), 32'b10);
    chk("addi_wb_rfwe_rfd_m", 32'({tr[3][2], tr[3][9], tr[3][10]}), 32'b100);

    // illegal opcode, MEM_LAT=0
    pin(0, 6'b111111, 22);
    chk("ill_decode", 32'(tr[1][20:17]), 32'd1);
    chk("ill_flag", 32'(tr[2][16]), 32'd1);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 2; i < 22; i++) begin
      chk($sformatf("trap_state%0d", i), 32'(tr[i][20:17]), 32'd13);
      chk($sformatf("trap_strobes%0d", i), 32'(tr[i][5:2]), 32'd0);
    end
`else
    chk("nop_next_fetch", 32'(tr[2][20:17]), 32'd0);
    chk("nop_flag_sticky", 32'(tr[5][16]), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
